// File: rtl/game_pkg.sv
// Shared game constants and types for the maze game video pipeline.
// Both the position controller and other per-frame blocks import this package.
package game_pkg;

  localparam logic [11:0] SCREEN_W = 12'd800;
  localparam logic [11:0] SCREEN_H = 12'd600;
  localparam logic [11:0] SPRITE_W = 12'd100;
  localparam logic [11:0] SPRITE_H = 12'd100;

  // Largest top-left corner that keeps the whole sprite on screen
  localparam logic [11:0] X_MAX_DFLT = SCREEN_W - SPRITE_W;
  localparam logic [11:0] Y_MAX_DFLT = SCREEN_H - SPRITE_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_QUERY = 2'd2,
    ST_WON   = 2'd3
  } pos_state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Vsync rising-edge detector plus a frame divider; move_slot pulses on the
// tick that completes each group of FRAME_DIV frames.
module frame_tick_gen #(
  parameter logic [3:0] FRAME_DIV = 4'd2
) (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  input  logic en,
  output logic move_slot
);

  logic       vsync_d;
  logic [3:0] frame_cnt;
  logic       tick;
  logic       last_frame;

  assign tick       = vsync_in & ~vsync_d;
  assign last_frame = (frame_cnt == FRAME_DIV - 4'd1);
  assign move_slot  = tick & last_frame;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_d   <= 1'b0;
      frame_cnt <= 4'd0;
    end else begin
      vsync_d <= vsync_in;
      if (en && tick) begin
        frame_cnt <= last_frame ? 4'd0 : frame_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/user_pos_ctrl.sv
// Player sprite position sequencer: samples keys once per move slot, clamps the
// candidate to the screen, and commits it only after the obstacle checker agrees.
import game_pkg::*;

module user_pos_ctrl #(
  parameter logic [11:0] X_INIT      = 12'd20,
  parameter logic [11:0] Y_INIT      = 12'd250,
  parameter logic [11:0] STEP        = 12'd4,
  parameter logic [11:0] X_MAX       = X_MAX_DFLT,
  parameter logic [11:0] Y_MAX       = Y_MAX_DFLT,
  parameter logic [3:0]  FRAME_DIV   = 4'd2,
  parameter logic [4:0]  ACK_TIMEOUT = 5'd16
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        game_won_in,
  input  logic        chk_ack,
  input  logic        chk_blocked,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        chk_req,
  output logic [11:0] chk_x,
  output logic [11:0] chk_y,
  output logic        frozen
);

  pos_state_t  state;
  dir_t        dir_r;
  logic [4:0]  to_cnt;
  logic        move_slot;
  logic [11:0] cand_x;
  logic [11:0] cand_y;
  logic        has_dir;
  logic        cand_moves;

  // Subtract with floor at zero; the 13th bit catches the underflow
  function automatic logic [11:0] sat_dec(input logic [11:0] v, input logic [11:0] step);
    logic signed [12:0] d;
    d = $signed({1'b0, v}) - $signed({1'b0, step});
    return d[12] ? 12'd0 : d[11:0];
  endfunction

  // Add with ceiling at lim; 13-bit sum so a carry cannot wrap past lim
  function automatic logic [11:0] sat_inc(input logic [11:0] v, input logic [11:0] step,
                                          input logic [11:0] lim);
    logic [12:0] s;
    s = {1'b0, v} + {1'b0, step};
    return (s > {1'b0, lim}) ? lim : s[11:0];
  endfunction

  frame_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_tick (
    .pclk      (pclk),
    .rst       (rst),
    .vsync_in  (vsync_in),
    .en        (state != ST_WON),
    .move_slot (move_slot)
  );

  always_comb begin
    cand_x  = x_pos;
    cand_y  = y_pos;
    has_dir = 1'b1;
    if (dir_r.up) begin
      cand_y = sat_dec(y_pos, STEP);
    end else if (dir_r.down) begin
      cand_y = sat_inc(y_pos, STEP, Y_MAX);
    end else if (dir_r.left) begin
      cand_x = sat_dec(x_pos, STEP);
    end else if (dir_r.right) begin
      cand_x = sat_inc(x_pos, STEP, X_MAX);
    end else begin
      has_dir = 1'b0;
    end
  end

  // A clamped candidate equal to the current spot is not worth a query
  assign cand_moves = has_dir && ((cand_x != x_pos) || (cand_y != y_pos));

  always_ff @(posedge pclk) begin
    if (rst) begin
      state   <= ST_IDLE;
      dir_r   <= '0;
      to_cnt  <= 5'd0;
      x_pos   <= X_INIT;
      y_pos   <= Y_INIT;
      chk_req <= 1'b0;
      chk_x   <= 12'd0;
      chk_y   <= 12'd0;
      frozen  <= 1'b0;
    end else if (game_won_in || state == ST_WON) begin
      // Winning overrides any in-flight query, tick or commit and is sticky
      state   <= ST_WON;
      chk_req <= 1'b0;
      frozen  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (move_slot) begin
            dir_r <= {key_up, key_down, key_left, key_right};
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (cand_moves) begin
            chk_x   <= cand_x;
            chk_y   <= cand_y;
            chk_req <= 1'b1;
            to_cnt  <= 5'd0;
            state   <= ST_QUERY;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_QUERY: begin
          if (chk_ack) begin
            if (!chk_blocked) begin
              x_pos <= chk_x;
              y_pos <= chk_y;
            end
            chk_req <= 1'b0;
            state   <= ST_IDLE;
          end else if (to_cnt == ACK_TIMEOUT - 5'd1) begin
            chk_req <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 5'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_pos_ctrl.sv
// Bench for user_pos_ctrl: the bench plays the timing chain and the obstacle
// checker, and predicts each frame from a plain-arithmetic model of the game rules.
module tb_user_pos_ctrl;

  localparam int STEP = 4;
  localparam int XMAX = 700;
  localparam int YMAX = 500;
  localparam int XI   = 20;
  localparam int YI   = 250;
  localparam int FDIV = 2;
  localparam int TMO  = 16;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_in = 1'b0;
  logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic        game_won_in = 1'b0;
  logic        chk_ack = 1'b0;
  logic        chk_blocked = 1'b0;
  logic [11:0] x_pos, y_pos, chk_x, chk_y;
  logic        chk_req, frozen;

  int checks = 0;
  int passed = 0;

  // Reference model state
  int mx, my, mticks;
  bit mfrozen;
  // Expected and observed per-frame results
  bit e_saw;
  int e_cx, e_cy, e_cyc, e_why;
  bit o_saw, o_stable;
  int o_cx, o_cy, o_cyc;

  user_pos_ctrl dut (
    .pclk        (pclk),
    .rst         (rst),
    .vsync_in    (vsync_in),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_left    (key_left),
    .key_right   (key_right),
    .game_won_in (game_won_in),
    .chk_ack     (chk_ack),
    .chk_blocked (chk_blocked),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .chk_req     (chk_req),
    .chk_x       (chk_x),
    .chk_y       (chk_y),
    .frozen      (frozen)
  );

  always #5 pclk = ~pclk;

  task automatic apply_reset();
    @(negedge pclk);
    rst = 1'b1; vsync_in = 1'b0; game_won_in = 1'b0; chk_ack = 1'b0; chk_blocked = 1'b0;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    mx = XI; my = YI; mticks = 0; mfrozen = 0;
  endtask

  task automatic set_keys(input bit u, input bit d, input bit l, input bit r);
    key_up = u; key_down = d; key_left = l; key_right = r;
  endtask

  // One 41-cycle frame: predict, drive vsync and answer as the checker, update model.
  // ack_at/won_at/rst_at name the request cycle (1-based) on which that event fires.
  task automatic step_frame(input int ack_at, input bit blk, input int won_at,
                            input int rst_at, input bit spur);
    int cx, cy, endc;
    bit mv;
    e_saw = 0; e_cx = 0; e_cy = 0; e_cyc = 0; e_why = 0;
    if (!mfrozen) begin
      mticks++;
      if (mticks % FDIV == 0) begin
        cx = mx; cy = my; mv = 1;
        if (key_up)         cy = (my - STEP < 0) ? 0 : my - STEP;
        else if (key_down)  cy = (my + STEP > YMAX) ? YMAX : my + STEP;
        else if (key_left)  cx = (mx - STEP < 0) ? 0 : mx - STEP;
        else if (key_right) cx = (mx + STEP > XMAX) ? XMAX : mx + STEP;
        else mv = 0;
        if (cx == mx && cy == my) mv = 0;
        if (mv) begin
          e_saw = 1; e_cx = cx; e_cy = cy;
          endc = TMO;
          if (ack_at >= 1 && ack_at <= endc) begin endc = ack_at; e_why = 1; end
          if (won_at >= 1 && won_at <= endc) begin endc = won_at; e_why = 2; end
          if (rst_at >= 1 && rst_at <= endc) begin endc = rst_at; e_why = 3; end
          e_cyc = endc;
        end
      end
    end
    o_saw = 0; o_stable = 1; o_cx = 0; o_cy = 0; o_cyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      vsync_in = (c < 3);
      rst = 1'b0; game_won_in = 1'b0;
      if (chk_req) begin
        if (!o_saw) begin
          o_cx = int'(chk_x); o_cy = int'(chk_y);
        end else if (int'(chk_x) != o_cx || int'(chk_y) != o_cy) begin
          o_stable = 0;
        end
        o_saw = 1; o_cyc++;
        chk_ack = 1'b0;
        chk_blocked = ($urandom_range(0, 1) != 0);
        if (o_cyc == ack_at) begin chk_ack = 1'b1; chk_blocked = blk; end
        if (o_cyc == won_at) game_won_in = 1'b1;
        if (o_cyc == rst_at) rst = 1'b1;
      end else begin
        chk_ack = spur ? ($urandom_range(0, 1) != 0) : 1'b0;
        chk_blocked = ($urandom_range(0, 1) != 0);
      end
    end
    @(negedge pclk);
    chk_ack = 1'b0; rst = 1'b0; game_won_in = 1'b0;
    if (e_saw) begin
      case (e_why)
        1: if (!blk) begin mx = e_cx; my = e_cy; end
        2: mfrozen = 1;
        3: begin mx = XI; my = YI; mticks = 0; mfrozen = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (x_pos !== 12'd20)  $display("FAIL reset_x: got %0d want 20", x_pos);  else passed++;
    checks++; if (y_pos !== 12'd250) $display("FAIL reset_y: got %0d want 250", y_pos); else passed++;
    checks++; if (chk_req !== 1'b0)  $display("FAIL reset_req: got %0d want 0", chk_req); else passed++;
    checks++; if (chk_x !== 12'd0)   $display("FAIL reset_chk_x: got %0d want 0", chk_x); else passed++;
    checks++; if (chk_y !== 12'd0)   $display("FAIL reset_chk_y: got %0d want 0", chk_y); else passed++;
    checks++; if (frozen !== 1'b0)   $display("FAIL reset_frozen: got %0d want 0", frozen); else passed++;
  endtask

  task automatic test_no_keys();
    set_keys(0, 0, 0, 0);
    for (int f = 0; f < 4; f++) begin
      step_frame(3, 0, 0, 0, 1);
      checks++; if (o_saw !== 1'b0) $display("FAIL idle_req f%0d: got %0d want 0", f, o_saw); else passed++;
      checks++; if (int'(x_pos) != XI || int'(y_pos) != YI)
        $display("FAIL idle_pos f%0d: got %0d,%0d want %0d,%0d", f, x_pos, y_pos, XI, YI); else passed++;
    end
  endtask

  task automatic test_right_moves();
    set_keys(0, 0, 0, 1);
    for (int f = 0; f < 4; f++) begin
      step_frame(3, 0, 0, 0, 0);
      checks++; if (o_saw !== e_saw) $display("FAIL right_req f%0d: got %0d want %0d", f, o_saw, e_saw); else passed++;
      if (e_saw) begin
        checks++; if (o_cx != e_cx || o_cy != e_cy)
          $display("FAIL right_cand f%0d: got %0d,%0d want %0d,%0d", f, o_cx, o_cy, e_cx, e_cy); else passed++;
        checks++; if (o_cyc != e_cyc) $display("FAIL right_req_len f%0d: got %0d want %0d", f, o_cyc, e_cyc); else passed++;
      end
      checks++; if (int'(x_pos) != mx) $display("FAIL right_x f%0d: got %0d want %0d", f, x_pos, mx); else passed++;
    end
    checks++; if (x_pos !== 12'd28) $display("FAIL right_final_x: got %0d want 28", x_pos); else passed++;
  endtask

  task automatic test_priority_blocked();
    set_keys(1, 0, 1, 0);
    for (int f = 0; f < 2; f++) begin
      step_frame(2, 1, 0, 0, 0);
      checks++; if (o_saw !== e_saw) $display("FAIL prio_req f%0d: got %0d want %0d", f, o_saw, e_saw); else passed++;
      if (e_saw) begin
        checks++; if (o_cy != my - STEP || o_cx != mx)
          $display("FAIL prio_cand: got %0d,%0d want %0d,%0d", o_cx, o_cy, mx, my - STEP); else passed++;
        checks++; if (o_stable !== 1'b1) $display("FAIL prio_stable: got %0d want 1", o_stable); else passed++;
      end
      checks++; if (int'(x_pos) != mx || int'(y_pos) != my)
        $display("FAIL prio_pos f%0d: got %0d,%0d want %0d,%0d", f, x_pos, y_pos, mx, my); else passed++;
    end
  endtask

  task automatic test_timeout();
    set_keys(0, 1, 0, 0);
    for (int f = 0; f < 4; f++) begin
      step_frame((f < 2) ? 0 : 5, 0, 0, 0, 0);
      checks++; if (o_saw !== e_saw) $display("FAIL tmo_req f%0d: got %0d want %0d", f, o_saw, e_saw); else passed++;
      if (e_saw) begin
        checks++; if (o_cyc != e_cyc) $display("FAIL tmo_req_len f%0d: got %0d want %0d", f, o_cyc, e_cyc); else passed++;
      end
      checks++; if (int'(y_pos) != my) $display("FAIL tmo_y f%0d: got %0d want %0d", f, y_pos, my); else passed++;
    end
  endtask

  task automatic test_clamp_zero();
    int guard;
    set_keys(1, 0, 0, 0);
    guard = 0;
    while (my > 0 && guard < 200) begin
      step_frame(1, 0, 0, 0, 0);
      guard++;
      if (e_saw) begin
        checks++; if (o_saw !== 1'b1 || o_cy != e_cy)
          $display("FAIL clamp_cand: got req=%0d y=%0d want req=1 y=%0d", o_saw, o_cy, e_cy); else passed++;
      end
      checks++; if (int'(y_pos) != my) $display("FAIL clamp_y: got %0d want %0d", y_pos, my); else passed++;
    end
    checks++; if (y_pos !== 12'd0) $display("FAIL clamp_floor: got %0d want 0", y_pos); else passed++;
    for (int f = 0; f < 2; f++) begin
      step_frame(1, 0, 0, 0, 0);
      checks++; if (o_saw !== 1'b0) $display("FAIL clamp_noreq f%0d: got %0d want 0", f, o_saw); else passed++;
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      set_keys($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0);
      step_frame($urandom_range(0, 18), $urandom_range(0, 2) == 0, 0, 0, 1);
      checks++; if (o_saw !== e_saw) $display("FAIL rnd_req f%0d: got %0d want %0d", f, o_saw, e_saw); else passed++;
      if (e_saw) begin
        checks++; if (o_cx != e_cx || o_cy != e_cy || o_cyc != e_cyc || !o_stable)
          $display("FAIL rnd_query f%0d: got %0d,%0d len %0d st %0d want %0d,%0d len %0d",
                   f, o_cx, o_cy, o_cyc, o_stable, e_cx, e_cy, e_cyc); else passed++;
      end
      checks++; if (int'(x_pos) != mx || int'(y_pos) != my)
        $display("FAIL rnd_pos f%0d: got %0d,%0d want %0d,%0d", f, x_pos, y_pos, mx, my); else passed++;
    end
  endtask

  task automatic test_won();
    int px, py;
    set_keys(0, 0, 0, 1);
    for (int f = 0; f < 4 && !mfrozen; f++) begin
      step_frame(2, 0, 2, 0, 0);
      if (e_saw) begin
        checks++; if (o_cyc != 2) $display("FAIL won_req_len: got %0d want 2", o_cyc); else passed++;
      end
    end
    checks++; if (frozen !== 1'b1)  $display("FAIL won_frozen: got %0d want 1", frozen); else passed++;
    checks++; if (chk_req !== 1'b0) $display("FAIL won_req_drop: got %0d want 0", chk_req); else passed++;
    checks++; if (int'(x_pos) != mx) $display("FAIL won_no_commit: got %0d want %0d", x_pos, mx); else passed++;
    px = mx; py = my;
    for (int f = 0; f < 4; f++) begin
      set_keys($urandom_range(0, 1) != 0, 0, $urandom_range(0, 1) != 0, 1);
      step_frame(1, 0, 0, 0, 1);
      checks++; if (o_saw !== 1'b0) $display("FAIL won_hold_req f%0d: got %0d want 0", f, o_saw); else passed++;
      checks++; if (int'(x_pos) != px || int'(y_pos) != py || frozen !== 1'b1)
        $display("FAIL won_hold f%0d: got %0d,%0d fz %0d want %0d,%0d fz 1", f, x_pos, y_pos, frozen, px, py); else passed++;
    end
    apply_reset();
    checks++; if (x_pos !== 12'd20 || y_pos !== 12'd250 || frozen !== 1'b0)
      $display("FAIL won_reset: got %0d,%0d fz %0d want 20,250 fz 0", x_pos, y_pos, frozen); else passed++;
  endtask

  task automatic test_reset_mid_query();
    bit hit;
    hit = 0;
    set_keys(0, 0, 1, 0);
    for (int f = 0; f < 4 && !hit; f++) begin
      step_frame(0, 0, 0, 3, 0);
      if (e_why == 3) hit = 1;
    end
    checks++; if (hit !== 1'b1 || o_cyc != 3) $display("FAIL rstq_len: got %0d want 3", o_cyc); else passed++;
    checks++; if (chk_req !== 1'b0 || x_pos !== 12'd20 || y_pos !== 12'd250 || frozen !== 1'b0)
      $display("FAIL rstq_state: got req %0d pos %0d,%0d fz %0d want req 0 pos 20,250 fz 0",
               chk_req, x_pos, y_pos, frozen); else passed++;
  endtask

  initial begin
    test_reset();
    test_no_keys();
    test_right_moves();
    test_priority_blocked();
    test_timeout();
    test_clamp_zero();
    test_random();
    test_won();
    test_reset_mid_query();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/user_pos_ctrl.md
Name: user_pos_ctrl

Overview:
- Sequences the player sprite position (x_pos, y_pos) that feeds the user-drawing stage of the video pipeline.
- Once per N frames, samples the direction keys and computes a clamped candidate position.
- Asks the maze obstacle checker, over a req/ack handshake, whether the candidate is free; commits it only if free.
- Freezes the position permanently once the game-won flag is raised, until reset.

Parameters:
- X_INIT, 12'd20: x_pos after reset.
- Y_INIT, 12'd250: y_pos after reset.
- STEP, 12'd4: pixels moved per accepted move.
- X_MAX, 12'd700: largest legal x_pos (screen width minus sprite width).
- Y_MAX, 12'd500: largest legal y_pos.
- FRAME_DIV, 4'd2: number of frames between move attempts (1..15).
- ACK_TIMEOUT, 5'd16: cycles to wait in QUERY before treating the move as blocked.

Ports:
- pclk, input, 1: pixel clock; the only clock.
- rst, input, 1: synchronous, active-high reset.
- vsync_in, input, 1: vertical sync from the timing chain; a rising edge marks the frame tick.
- key_up, key_down, key_left, key_right, input, 1 each: debounced key levels.
- game_won_in, input, 1: win flag from the drawing stage.
- chk_ack, input, 1: one-cycle response strobe from the obstacle checker.
- chk_blocked, input, 1: checker verdict; valid only while chk_ack=1.
- x_pos, output, 12: committed sprite x.
- y_pos, output, 12: committed sprite y.
- chk_req, output, 1: query request; held high until ack or timeout.
- chk_x, chk_y, output, 12 each: candidate position; stable while chk_req=1.
- frozen, output, 1: high in the WON state.

Behaviour:
- Reset values: x_pos=X_INIT, y_pos=Y_INIT, chk_req=0, chk_x=0, chk_y=0, frozen=0. Internally: vsync_d=0, frame_cnt=0, to_cnt=0, state=IDLE.
- All outputs are registered.
- Frame tick: tick = vsync_in & ~vsync_d.
- frame_cnt increments on each tick and wraps FRAME_DIV-1 → 0. It counts in every state except WON.
- States: IDLE, CALC, QUERY, WON.
- IDLE:
  - On a tick with frame_cnt==FRAME_DIV-1: latch the four keys into dir_r and go to CALC.
  - Ticks in any other state are ignored, not queued.
- Key priority: up > down > left > right. Exactly one axis moves per attempt.
- CALC (one cycle):
  - Compute the candidate in 13-bit arithmetic.
  - Up: y - STEP, clamped to 0.
  - Down: y + STEP, clamped to Y_MAX.
  - Left and right: same rule on x, clamped to 0 and X_MAX.
  - If no key, or candidate == current position: go to IDLE, no request issued.
  - Otherwise, at the next edge: chk_x/chk_y <= candidate, chk_req <= 1, to_cnt <= 0, state QUERY.
- QUERY:
  - chk_req is high from the first QUERY cycle.
  - On chk_ack: if !chk_blocked, commit x_pos/y_pos <= chk_x/chk_y on the same edge. Either way chk_req <= 0 and state <= IDLE.
  - An accepted move therefore appears on x_pos/y_pos one edge after the ack cycle.
  - to_cnt increments each QUERY cycle. When it reaches ACK_TIMEOUT-1 with no ack: drop chk_req, no commit, go to IDLE.
  - chk_ack while not in QUERY is ignored.
- WON:
  - Entered from any state on the edge where game_won_in=1, with priority over ack, tick and commit.
  - An outstanding request is abandoned (chk_req <= 0), frozen <= 1.
  - Position is held. The state is left only by rst.
- rst asserted mid-QUERY: chk_req drops on that edge and all values return to reset values.
- Position never leaves [0, X_MAX] × [0, Y_MAX]; no wrap-around.

Decomposition:
- Shared package (game_pkg): state encoding; constants SCREEN_W=800, SCREEN_H=600, SPRITE_W=100, SPRITE_H=100. X_MAX and Y_MAX defaults derive from these.
- Sub-module frame_tick_gen: vsync edge detect plus FRAME_DIV counter, output move_slot pulse. Reusable by other per-frame blocks.
- The FSM and the clamp arithmetic stay in user_pos_ctrl.

Test Plan:
- Reset, no keys, 4 frames → x_pos=20, y_pos=250; chk_req never high.
- key_right held, FRAME_DIV=2, checker acks free after 3 cycles → chk_x=24 on every second vsync rise; x_pos 20→24→28; chk_req high exactly 3 cycles per query.
- x_pos=2, key_left, checker free → chk_x=0, x_pos=0. Next attempt: candidate==current, so no chk_req pulse.
- key_up and key_left together → y-axis query only (chk_y=246, chk_x=20). chk_blocked=1 → position unchanged.
- No ack → chk_req drops after 16 cycles, position unchanged, next slot retries.
- game_won_in pulsed mid-QUERY → chk_req=0 next edge, frozen=1. Later acks and keys have no effect until rst, after which x_pos=20, y_pos=250, frozen=0.
